div_ctrl: RTL and testbench

//  Control unit for the shift-subtract divider datapath. It divides a 2N-bit

---
 rtl/div_ctrl.sv | 116 +++++++++++
 tb/tb_div_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Sequencer for a shift-subtract divider (2N-bit / N-bit).
//                Drives LOAD/SHIFT/SUB, flags overflow, pulses Done.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl #(
    parameter int N = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ST,
    input  logic       C,
    output logic       LOAD,
    output logic       SHIFT,
    output logic       SUB,
    output logic       BUSY,
    output logic       Done,
    output logic       V,
    output logic [1:0] STATE
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_cnt_init = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CHK  = 2'd1,
        S_LOOP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_sub_last, w_sub_last_next;
    logic          r_v, w_v_next;
    logic          r_done;
    logic          w_load, w_shift, w_sub;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sub_last <= 1'b0;
            r_v        <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_sub_last <= w_sub_last_next;
            r_v        <= w_v_next;
            r_done     <= (w_next == S_DONE);
        end
    end

    always_comb begin
        w_next          = r_state;
        w_cnt_next      = r_cnt;
        w_sub_last_next = r_sub_last;
        w_v_next        = r_v;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        w_sub           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ST) begin
                    w_load   = 1'b1;
                    w_v_next = 1'b0;
                    w_next   = S_CHK;
                end
            end
            S_CHK: begin
                // Upper half already >= divisor means the quotient cannot fit.
                if (C) begin
                    w_v_next = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    w_shift         = 1'b1;
                    w_cnt_next      = c_cnt_init;
                    w_sub_last_next = 1'b0;
                    w_next          = S_LOOP;
                end
            end
            S_LOOP: begin
                // C is ignored right after a SUB so SUBs never run back-to-back.
                if (C && !r_sub_last) begin
                    w_sub           = 1'b1;
                    w_sub_last_next = 1'b1;
                end else if (r_cnt != '0) begin
                    w_shift         = 1'b1;
                    w_cnt_next      = r_cnt - CW'(1);
                    w_sub_last_next = 1'b0;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign LOAD  = w_load  & ~RST;
    assign SHIFT = w_shift & ~RST;
    assign SUB   = w_sub   & ~RST;
    assign BUSY  = (r_state != S_IDLE);
    assign Done  = r_done;
    assign V     = r_v;
    assign STATE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_ctrl
//  Description : Self-checking bench for div_ctrl with a behavioural datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ST  = 1'b0;
    logic       C;
    logic       LOAD, SHIFT, SUB, BUSY, Done, V;
    logic [1:0] STATE;

    logic [W-1:0] dividend_in = '0;
    logic [N-1:0] divisor_in  = '0;
    logic [W:0]   dp = '0;
    logic [N-1:0] dv = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_load  = 0;
    int n_shift = 0;
    int n_sub   = 0;

    div_ctrl #(.N(N)) dut (
        .CLK(CLK), .RST(RST), .ST(ST), .C(C),
        .LOAD(LOAD), .SHIFT(SHIFT), .SUB(SUB),
        .BUSY(BUSY), .Done(Done), .V(V), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Behavioural divider datapath: (2N+1)-bit dividend register, N-bit divisor.
    assign C = (dp[W:N] >= {1'b0, dv});
    always @(posedge CLK) begin
        if (LOAD) begin
            dp <= {1'b0, dividend_in};
            dv <= divisor_in;
        end else if (SHIFT) begin
            dp <= {dp[W-1:0], 1'b0};
        end else if (SUB) begin
            dp <= {dp[W:N] - {1'b0, dv}, dp[N-1:1], 1'b1};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("onehot", 32'($countones({LOAD, SHIFT, SUB}) <= 1), 32'd1);
        if (RST) chk("rst_strobes", 32'({LOAD, SHIFT, SUB}), 32'd0);
        if (LOAD)  n_load++;
        if (SHIFT) n_shift++;
        if (SUB)   n_sub++;
    end

    typedef struct {
        logic [W-1:0] dd;
        logic [N-1:0] ds;
        bit           hold;
        logic [N-1:0] q;
        logic [N-1:0] r;
        bit           v;
        int           lat;
    } vec_t;

    // Arithmetic reference: overflow if divisor is zero or quotient exceeds N bits.
    task automatic ref_model(input logic [W-1:0] dd, input logic [N-1:0] ds,
                             output vec_t e);
        int q;
        e.dd = dd; e.ds = ds; e.hold = 1'b0;
        if (ds == 0 || (int'(dd) / int'(ds)) > (2 ** N - 1)) begin
            e.v = 1'b1; e.q = '0; e.r = '0; e.lat = 2;
        end else begin
            q = int'(dd) / int'(ds);
            e.v = 1'b0;
            e.q = N'(q);
            e.r = N'(int'(dd) % int'(ds));
            e.lat = 2 + N + $countones(e.q);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1; RST = 1'b1; ST = 1'b0;
        @(posedge CLK); #1; RST = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        int  lat;
        bit  got;
        lat = 0; got = 1'b0;
        @(posedge CLK); #1;
        dividend_in = t.dd; divisor_in = t.ds; ST = 1'b1;
        n_load = 0; n_shift = 0; n_sub = 0;
        for (int e = 1; e <= 2 * N + 6 && !got; e++) begin
            @(posedge CLK); #1;
            if (!t.hold) ST = 1'b0;
            @(negedge CLK);
            if (e == 1) begin
                chk("v_clear_at_start", 32'(V), 32'd0);
                chk("busy_at_start", 32'(BUSY), 32'd1);
            end
            if (Done) begin
                got = 1'b1; lat = e;
            end
        end
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
            ST = 1'b0;
            do_reset();
            return;
        end
        chk("latency", 32'(lat), 32'(t.lat));
        chk("latency_bound", 32'(lat <= 2 * N + 2), 32'd1);
        chk("v_flag", 32'(V), 32'(t.v));
        chk("load_count", 32'(n_load), 32'd1);
        if (t.v) begin
            chk("ovf_shifts", 32'(n_shift), 32'd0);
            chk("ovf_subs", 32'(n_sub), 32'd0);
        end else begin
            chk("quotient", 32'(dp[N-1:0]), 32'(t.q));
            chk("remainder", 32'(dp[W-1:N]), 32'(t.r));
            chk("shift_count", 32'(n_shift), 32'(N));
            chk("sub_count", 32'(n_sub), 32'($countones(t.q)));
        end
        @(posedge CLK); #1; ST = 1'b0;
        @(negedge CLK);
        chk("done_one_cycle", 32'(Done), 32'd0);
        chk("idle_after_done", 32'(STATE), 32'd0);
        chk("v_hold", 32'(V), 32'(t.v));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t rv;
        tbl[0] = '{8'd135, 4'd13, 1'b0, 4'd10, 4'd5,  1'b0, 8};
        tbl[1] = '{8'd165, 4'd4,  1'b0, 4'd0,  4'd0,  1'b1, 2};
        tbl[2] = '{8'd6,   4'd0,  1'b0, 4'd0,  4'd0,  1'b1, 2};
        tbl[3] = '{8'd6,   4'd4,  1'b0, 4'd1,  4'd2,  1'b0, 7};
        tbl[4] = '{8'd135, 4'd13, 1'b1, 4'd10, 4'd5,  1'b0, 8};
        tbl[5] = '{8'd224, 4'd15, 1'b0, 4'd14, 4'd14, 1'b0, 9};
        tbl[6] = '{8'd0,   4'd5,  1'b0, 4'd0,  4'd0,  1'b0, 6};
        tbl[7] = '{8'd255, 4'd15, 1'b0, 4'd0,  4'd0,  1'b1, 2};

        repeat (3) @(posedge CLK);
        #1; RST = 1'b0;
        @(negedge CLK);
        chk("reset_state", 32'(STATE), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_v", 32'(V), 32'd0);
        chk("reset_load", 32'(LOAD), 32'd0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset together with start: start is lost.
        @(posedge CLK); #1; RST = 1'b1; ST = 1'b1;
        @(posedge CLK); #1; RST = 1'b0; ST = 1'b0;
        @(negedge CLK);
        chk("rst_st_state", 32'(STATE), 32'd0);
        chk("rst_st_busy", 32'(BUSY), 32'd0);

        // Abort mid-divide after the second SHIFT.
        @(posedge CLK); #1;
        dividend_in = 8'd135; divisor_in = 4'd13; ST = 1'b1;
        @(posedge CLK); #1; ST = 1'b0;
        repeat (3) @(posedge CLK);
        #1; RST = 1'b1;
        @(negedge CLK);
        chk("abort_no_done_during_rst", 32'(Done), 32'd0);
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);
        chk("abort_state", 32'(STATE), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        repeat (3) begin
            @(negedge CLK);
            chk("abort_no_done_later", 32'(Done), 32'd0);
        end
        run_vec(tbl[0]);

        for (int k = 0; k < 200; k++) begin
            logic [N-1:0] ds;
            logic [W-1:0] dd;
            if ($urandom_range(0, 3) == 0) begin
                ds = N'($urandom_range(0, 2 ** N - 1));
                dd = W'($urandom_range(0, 2 ** W - 1));
            end else begin
                ds = N'($urandom_range(1, 2 ** N - 1));
                dd = W'($urandom_range(0, int'(ds) * (2 ** N) - 1));
            end
            ref_model(dd, ds, rv);
            rv.hold = bit'($urandom_range(0, 1));
            run_vec(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
